prf_operand_collector: RTL
==========================

// Module: prf_operand_collector
// PURPOSE
//   Read-requester end of the PRF register-read interface. Takes one issued op with up to two source PRs
//   (A, B) and drives one read-requester slot per operand. It handles ack/retry and fetches data from the
//   acked bank/port one cycle later, or snoops the PRF writeback bus to capture a value early.
//   Sits between an issue queue and a functional unit. The op is handed downstream over valid/ready.
// PARAMETERS
//   LOG_PR_COUNT        7  log2 of physical register count
//   LOG_PRF_BANK_COUNT  2  log2 of PRF banks; PRF_BANK_COUNT = 2**LOG_PRF_BANK_COUNT; bank = PR[LOG_PRF_BANK_COUNT-1:0]
//   LOG_ROB_ENTRIES     7  ROB index width
// PORTS
//   CLK                            in   1                             clock
//   nRST                           in   1                             async active-low reset
//   issue_valid                    in   1                             op offered by issue queue
//   issue_ready                    out  1                             collector can accept op
//   issue_A_need / issue_B_need    in   1 each                        operand must be read
//   issue_A_PR / issue_B_PR        in   LOG_PR_COUNT each             source PRs
//   issue_dest_PR                  in   LOG_PR_COUNT                  passthrough tag
//   issue_ROB_index                in   LOG_ROB_ENTRIES               passthrough tag
//   flush                          in   1                             sync kill of held op
//   reg_read_req_valid_by_rr       out  2                             [0]=A, [1]=B read request
//   reg_read_req_PR_by_rr          out  2*LOG_PR_COUNT                requested PRs
//   reg_read_ack_by_rr             in   2                             PRF grant, same cycle as request
//   reg_read_port_by_rr            in   2                             granted bank read port
//   reg_read_data_by_bank_by_port  in   PRF_BANK_COUNT*2*32           read data, valid cycle after ack
//   WB_bus_valid_by_bank           in   PRF_BANK_COUNT                writeback bus snoop
//   WB_bus_data_by_bank            in   PRF_BANK_COUNT*32
//   WB_bus_upper_PR_by_bank        in   PRF_BANK_COUNT*(LOG_PR_COUNT-LOG_PRF_BANK_COUNT)
//   op_valid                       out  1                             collected op to FU
//   op_ready                       in   1                             FU accepts
//   op_A_data / op_B_data          out  32 each                       operand values; 0 if not needed
//   op_dest_PR / op_ROB_index      out  LOG_PR_COUNT / LOG_ROB_ENTRIES  registered tags
// BEHAVIOUR
//   - Reset (async, nRST=0): state IDLE; both operand slots DONE.
//     Reset values: op_valid=0, req_valid=0, req_PR=0, all data and tag regs 0, issue_ready=1.
//     Reset mid-op drops the op silently.
//   - Top FSM: IDLE -> COLLECT -> OUT.
//     - issue_ready = (IDLE) | (OUT & op_ready).
//     - Accept = issue_valid & issue_ready: latch PRs and tags.
//       Each needed slot goes to REQ; an unneeded slot goes to DONE with data 0.
//     - If no slot is needed, go straight to OUT.
//   - Slot FSM (per operand): REQ -> WAIT -> DONE.
//     - REQ: req_valid=1 (registered), req_PR=latched PR.
//       - WB hit (valid[bank] & upper_PR match): capture WB data and go to DONE; a concurrent ack is ignored.
//       - Else if ack: latch port and go to WAIT.
//       - Else stay in REQ and retry next cycle; there is no retry limit.
//     - WAIT: req_valid=0; capture reg_read_data_by_bank_by_port[bank][port], then go to DONE.
//   - COLLECT -> OUT on the edge where both slots' next state is DONE.
//     op_valid=1 in OUT; data and tags are held stable until op_ready.
//   - Best-case latency: accept at edge 0; ack in cycle 1; data in cycle 2; op_valid asserted in cycle 3.
//     With a WB hit in cycle 1, op_valid is asserted in cycle 2.
//   - OUT & op_ready & issue_valid: back-to-back accept in the same edge, with no bubble.
//   - flush (sync) wins over everything: next state IDLE, slots DONE, req_valid=0, op_valid=0.
//     An ack received in the flush cycle is discarded. issue_ready is forced to 0 during the flush cycle.
//   - A and B may name the same PR; the slots are handled independently.
//     The PRF must tolerate duplicate requests.
// TESTING
//   1. Reset: nRST=0 mid-COLLECT -> op_valid=0, req_valid=00, issue_ready=1 while in reset.
//   2. A=PR 0x05, B=PR 0x12, both acked in cycle 1 (ports 0,1); bank1 port0=0xDEADBEEF, bank2 port1=0x12345678
//      -> op_valid in cycle 3 with A=0xDEADBEEF, B=0x12345678.
//   3. A not acked for 3 cycles, B acked immediately -> req_valid=01 held 3 cycles; op_valid 3 cycles later than case 2.
//   4. A=PR 0x09 pending; WB bus bank1 valid, upper_PR=0x02, data 0xCAFEF00D
//      -> A captured, req_valid[0] drops next cycle.
//   5. Neither operand needed, op_ready=0 for 2 cycles then 1, issue_valid held
//      -> op_valid the cycle after accept; second op accepted on the handshake edge.
//   6. flush during WAIT of both slots -> op_valid never asserted; next issue proceeds normally.

Source files
------------

// File: rtl/prf_operand_collector_if.sv
// Bus bundle between the operand collector and its neighbours: the issue
// queue that offers ops, the PRF read arbiter, the writeback bus and the
// functional unit that consumes collected ops.
// The master modport is the collector's side. The slave modport is the
// environment's side.
interface prf_operand_collector_if #(
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_ROB_ENTRIES    = 7
);
  localparam int PRF_BANK_COUNT = 2 ** LOG_PRF_BANK_COUNT;
  localparam int UPPER_PR_W     = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  // issue side
  logic                          issue_valid;
  logic                          issue_ready;
  logic                          issue_A_need;
  logic                          issue_B_need;
  logic [LOG_PR_COUNT-1:0]       issue_A_PR;
  logic [LOG_PR_COUNT-1:0]       issue_B_PR;
  logic [LOG_PR_COUNT-1:0]       issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index;
  logic                          flush;

  // PRF read requester, one slot per operand ([0]=A, [1]=B)
  logic [1:0]                    reg_read_req_valid_by_rr;
  logic [2*LOG_PR_COUNT-1:0]     reg_read_req_PR_by_rr;
  logic [1:0]                    reg_read_ack_by_rr;
  logic [1:0]                    reg_read_port_by_rr;
  logic [PRF_BANK_COUNT*2*32-1:0] reg_read_data_by_bank_by_port;

  // writeback bus snoop
  logic [PRF_BANK_COUNT-1:0]            WB_bus_valid_by_bank;
  logic [PRF_BANK_COUNT*32-1:0]         WB_bus_data_by_bank;
  logic [PRF_BANK_COUNT*UPPER_PR_W-1:0] WB_bus_upper_PR_by_bank;

  // collected op to the functional unit
  logic                          op_valid;
  logic                          op_ready;
  logic [31:0]                   op_A_data;
  logic [31:0]                   op_B_data;
  logic [LOG_PR_COUNT-1:0]       op_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    op_ROB_index;

  modport master (
    input  issue_valid, issue_A_need, issue_B_need, issue_A_PR, issue_B_PR,
           issue_dest_PR, issue_ROB_index, flush,
           reg_read_ack_by_rr, reg_read_port_by_rr, reg_read_data_by_bank_by_port,
           WB_bus_valid_by_bank, WB_bus_data_by_bank, WB_bus_upper_PR_by_bank,
           op_ready,
    output issue_ready, reg_read_req_valid_by_rr, reg_read_req_PR_by_rr,
           op_valid, op_A_data, op_B_data, op_dest_PR, op_ROB_index
  );

  modport slave (
    output issue_valid, issue_A_need, issue_B_need, issue_A_PR, issue_B_PR,
           issue_dest_PR, issue_ROB_index, flush,
           reg_read_ack_by_rr, reg_read_port_by_rr, reg_read_data_by_bank_by_port,
           WB_bus_valid_by_bank, WB_bus_data_by_bank, WB_bus_upper_PR_by_bank,
           op_ready,
    input  issue_ready, reg_read_req_valid_by_rr, reg_read_req_PR_by_rr,
           op_valid, op_A_data, op_B_data, op_dest_PR, op_ROB_index
  );
endinterface

// File: rtl/prf_operand_collector.sv
// Operand collector: accepts one issued op, fetches up to two source
// operands from the banked PRF or the writeback bus, and hands the
// completed op to the functional unit over valid/ready.
// Top FSM: IDLE -> COLLECT -> OUT.
// Per-operand slot FSM: REQ -> WAIT -> DONE.
module prf_operand_collector #(
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_ROB_ENTRIES    = 7
) (
  input logic CLK,
  input logic nRST,
  prf_operand_collector_if.master bus
);
  localparam int UPPER_PR_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_OUT} top_state_t;
  typedef enum logic [1:0] {SL_DONE, SL_REQ, SL_WAIT} slot_state_t;

  top_state_t                 state_q, state_d;
  slot_state_t                slot_q [2];
  slot_state_t                slot_d [2];
  logic [LOG_PR_COUNT-1:0]    pr_q   [2];
  logic                       port_q [2];
  logic                       port_d [2];
  logic [31:0]                data_q [2];
  logic [31:0]                data_d [2];
  logic [1:0]                 req_valid_q;
  logic [LOG_PR_COUNT-1:0]    dest_q;
  logic [LOG_ROB_ENTRIES-1:0] rob_q;

  logic                    accept;
  logic                    any_need;
  logic [1:0]              need;
  logic [LOG_PR_COUNT-1:0] issue_pr [2];
  logic [1:0]              wb_hit;
  logic [31:0]             wb_data [2];
  logic [31:0]             rd_data [2];

  assign need        = {bus.issue_B_need, bus.issue_A_need};
  assign any_need    = |need;
  assign issue_pr[0] = bus.issue_A_PR;
  assign issue_pr[1] = bus.issue_B_PR;

  // A flush cycle never accepts, so a killed op cannot be replaced in the same edge.
  assign bus.issue_ready = !bus.flush &&
                           ((state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.op_ready));
  assign accept          = bus.issue_valid && bus.issue_ready;

  // Per-slot bank decode, writeback match and read-data selection.
  for (genvar i = 0; i < 2; i++) begin : g_slot
    logic [LOG_PRF_BANK_COUNT-1:0] bank;
    logic [LOG_PRF_BANK_COUNT:0]   rd_sel;
    assign bank       = pr_q[i][LOG_PRF_BANK_COUNT-1:0];
    assign rd_sel     = {bank, port_q[i]};
    assign wb_hit[i]  = bus.WB_bus_valid_by_bank[bank] &&
                        (bus.WB_bus_upper_PR_by_bank[int'(bank)*UPPER_PR_W +: UPPER_PR_W] ==
                         pr_q[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
    assign wb_data[i] = bus.WB_bus_data_by_bank[int'(bank)*32 +: 32];
    assign rd_data[i] = bus.reg_read_data_by_bank_by_port[int'(rd_sel)*32 +: 32];
  end

  // Slot next-state: writeback hit beats ack, accept reloads, flush kills.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    slot_d = slot_q;
    port_d = port_q;
    data_d = data_q;
    for (int i = 0; i < 2; i++) begin
      case (slot_q[i])
        SL_REQ: begin
          if (wb_hit[i]) begin
            data_d[i] = wb_data[i];
            slot_d[i] = SL_DONE;
          end else if (bus.reg_read_ack_by_rr[i]) begin
            port_d[i] = bus.reg_read_port_by_rr[i];
            slot_d[i] = SL_WAIT;
          end
        end
        SL_WAIT: begin
          data_d[i] = rd_data[i];
          slot_d[i] = SL_DONE;
        end
        default: ;
      endcase
      if (accept) begin
        data_d[i] = '0;
        slot_d[i] = need[i] ? SL_REQ : SL_DONE;
      end
      if (bus.flush) slot_d[i] = SL_DONE;
    end
  end

  // Top next-state: leave COLLECT once both slots land in DONE; back-to-back from OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = any_need ? ST_COLLECT : ST_OUT;
      end
      ST_COLLECT: begin
        if ((slot_d[0] == SL_DONE) && (slot_d[1] == SL_DONE)) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (accept)           state_d = any_need ? ST_COLLECT : ST_OUT;
        else if (bus.op_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  // State, operand and tag registers; the request valid is registered from the slot next-state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      req_valid_q <= '0;
      dest_q      <= '0;
      rob_q       <= '0;
      // NOTE: the operand arrays are a handful of flops, not a RAM, so they are reset like any other register.
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= SL_DONE;
        pr_q[i]   <= '0;
        port_q[i] <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      for (int i = 0; i < 2; i++) begin
        slot_q[i]      <= slot_d[i];
        port_q[i]      <= port_d[i];
        data_q[i]      <= data_d[i];
        req_valid_q[i] <= (slot_d[i] == SL_REQ);
        if (accept) pr_q[i] <= issue_pr[i];
      end
      if (accept) begin
        dest_q <= bus.issue_dest_PR;
        rob_q  <= bus.issue_ROB_index;
      end
    end
  end

  assign bus.reg_read_req_valid_by_rr = req_valid_q;
  assign bus.reg_read_req_PR_by_rr    = {pr_q[1], pr_q[0]};
  assign bus.op_valid                 = (state_q == ST_OUT);
  assign bus.op_A_data                = data_q[0];
  assign bus.op_B_data                = data_q[1];
  assign bus.op_dest_PR               = dest_q;
  assign bus.op_ROB_index             = rob_q;
endmodule
